// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : Circular in-order retirement queue for a Tomasulo core.
//             Allocates one tag per issued instruction and captures CDB
//             results. It forwards ready results to operand lookup and
//             retires at most one entry per cycle. A mispredicted
//             control-flow entry raises a one-cycle flush together with
//             the correct fetch PC.
//  Ports    : clk_in/rst_in/rdy_in     clock, sync reset, global stall (low)
//             issue_*                  allocation request at the tail
//             issue_tag, rob_full      next tag to allocate, queue full
//             query_tag/ready/value    two operand lookup ports
//             cdb_*                    result broadcast
//             rob_commit_*, commit_*   register-file commit pulse and data
//             store_commit_*           store retirement pulse and tag
//             clear_signal, clear_pc   misprediction flush pulse and PC
//  Revision : 1.0  initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [4:0]           issue_rd_id,
    input  logic                 issue_is_branch,
    input  logic                 issue_is_store,
    input  logic [31:0]          issue_pred_pc,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [31:0]          query_value_1,
    output logic [31:0]          query_value_2,
    input  logic                 cdb_signal,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_value,
    input  logic [31:0]          cdb_next_pc,
    output logic                 rob_commit_signal,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic [31:0]          commit_rd_value,
    output logic                 store_commit_signal,
    output logic [ROB_WIDTH-1:0] store_commit_tag,
    output logic                 clear_signal,
    output logic [31:0]          clear_pc
);

    localparam int                 DEPTH   = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] C_DEPTH = (ROB_WIDTH + 1)'(DEPTH);

    // Queue pointers and occupancy
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Entry storage
    logic [DEPTH-1:0]     ready_q;
    logic [DEPTH-1:0]     br_q;
    logic [DEPTH-1:0]     st_q;
    logic [4:0]           rd_q    [DEPTH];
    logic [31:0]          value_q [DEPTH];
    logic [31:0]          npc_q   [DEPTH];
    logic [31:0]          pred_q  [DEPTH];

    logic issue_fire;
    logic cdb_fire;
    logic commit_fire;
    logic mispredict;

    assign issue_tag = tail_q;
    assign rob_full  = (count_q == C_DEPTH);

    // The flush cycle (clear_signal high) blocks every state change so that
    // the emptied queue is seen by the front end before new work arrives.
    always_comb begin
        issue_fire  = issue_signal && !rob_full && !clear_signal;
        cdb_fire    = cdb_signal && !clear_signal;
        commit_fire = (count_q != '0) && ready_q[head_q] && !clear_signal;
        mispredict  = commit_fire && br_q[head_q] && (npc_q[head_q] != pred_q[head_q]);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (issue_fire) begin
            tail_d = tail_q + ROB_WIDTH'(1);
        end
        if (commit_fire) begin
            head_d = head_q + ROB_WIDTH'(1);
        end
        if (issue_fire && !commit_fire) begin
            count_d = count_q + (ROB_WIDTH + 1)'(1);
        end else if (!issue_fire && commit_fire) begin
            count_d = count_q - (ROB_WIDTH + 1)'(1);
        end
        // A mispredict discards every younger entry, including one issued
        // on this very edge.
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Operand lookup with same-cycle CDB bypass taking priority
    always_comb begin
        query_ready_1 = ready_q[query_tag_1];
        query_value_1 = value_q[query_tag_1];
        query_ready_2 = ready_q[query_tag_2];
        query_value_2 = value_q[query_tag_2];
        if (cdb_signal && (cdb_tag == query_tag_1)) begin
            query_ready_1 = 1'b1;
            query_value_1 = cdb_value;
        end
        if (cdb_signal && (cdb_tag == query_tag_2)) begin
            query_ready_2 = 1'b1;
            query_value_2 = cdb_value;
        end
    end

    // Pointers and ready bits
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (mispredict) begin
                ready_q <= '0;
            end else begin
                if (cdb_fire) begin
                    ready_q[cdb_tag] <= 1'b1;
                end
                // A fresh allocation must start not-ready even if a stray
                // broadcast names the same slot.
                if (issue_fire) begin
                    ready_q[tail_q] <= 1'b0;
                end
            end
        end
    end

    // Entry payload; only read once the matching ready bit is set
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (cdb_fire) begin
                value_q[cdb_tag] <= cdb_value;
                npc_q[cdb_tag]   <= cdb_next_pc;
            end
            if (issue_fire) begin
                rd_q[tail_q]   <= issue_rd_id;
                br_q[tail_q]   <= issue_is_branch;
                st_q[tail_q]   <= issue_is_store;
                pred_q[tail_q] <= issue_pred_pc;
            end
        end
    end

    // Registered retirement outputs: pulses drop on any non-committing
    // rdy_in-high cycle, buses keep their last value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rob_commit_signal   <= 1'b0;
            commit_rd_tag       <= '0;
            commit_rd_value     <= '0;
            store_commit_signal <= 1'b0;
            store_commit_tag    <= '0;
            clear_signal        <= 1'b0;
            clear_pc            <= '0;
        end else if (rdy_in) begin
            rob_commit_signal   <= commit_fire && (rd_q[head_q] != 5'd0);
            store_commit_signal <= commit_fire && st_q[head_q];
            clear_signal        <= mispredict;
            if (commit_fire && (rd_q[head_q] != 5'd0)) begin
                commit_rd_tag   <= head_q;
                commit_rd_value <= value_q[head_q];
            end
            if (commit_fire && st_q[head_q]) begin
                store_commit_tag <= head_q;
            end
            if (mispredict) begin
                clear_pc <= npc_q[head_q];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Self-checking bench for reorder_buffer. Directed scenarios
//             followed by random traffic, all compared every cycle against
//             a queue-based reference model of the retirement rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int W = 4;
    localparam int D = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          issue_signal = 1'b0;
    logic [4:0]    issue_rd_id = '0;
    logic          issue_is_branch = 1'b0;
    logic          issue_is_store = 1'b0;
    logic [31:0]   issue_pred_pc = '0;
    logic [W-1:0]  issue_tag;
    logic          rob_full;
    logic [W-1:0]  query_tag_1 = '0;
    logic [W-1:0]  query_tag_2 = '0;
    logic          query_ready_1, query_ready_2;
    logic [31:0]   query_value_1, query_value_2;
    logic          cdb_signal = 1'b0;
    logic [W-1:0]  cdb_tag = '0;
    logic [31:0]   cdb_value = '0;
    logic [31:0]   cdb_next_pc = '0;
    logic          rob_commit_signal;
    logic [W-1:0]  commit_rd_tag;
    logic [31:0]   commit_rd_value;
    logic          store_commit_signal;
    logic [W-1:0]  store_commit_tag;
    logic          clear_signal;
    logic [31:0]   clear_pc;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .issue_signal        (issue_signal),
        .issue_rd_id         (issue_rd_id),
        .issue_is_branch     (issue_is_branch),
        .issue_is_store      (issue_is_store),
        .issue_pred_pc       (issue_pred_pc),
        .issue_tag           (issue_tag),
        .rob_full            (rob_full),
        .query_tag_1         (query_tag_1),
        .query_tag_2         (query_tag_2),
        .query_ready_1       (query_ready_1),
        .query_ready_2       (query_ready_2),
        .query_value_1       (query_value_1),
        .query_value_2       (query_value_2),
        .cdb_signal          (cdb_signal),
        .cdb_tag             (cdb_tag),
        .cdb_value           (cdb_value),
        .cdb_next_pc         (cdb_next_pc),
        .rob_commit_signal   (rob_commit_signal),
        .commit_rd_tag       (commit_rd_tag),
        .commit_rd_value     (commit_rd_value),
        .store_commit_signal (store_commit_signal),
        .store_commit_tag    (store_commit_tag),
        .clear_signal        (clear_signal),
        .clear_pc            (clear_pc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: in-order list of live tags plus per-tag attributes
    int          q[$];
    bit          m_ready [D];
    logic [31:0] m_val   [D];
    logic [31:0] m_npc   [D];
    logic [31:0] m_pred  [D];
    logic [4:0]  m_rd    [D];
    bit          m_br    [D];
    bit          m_st    [D];
    int          m_tail;
    bit          e_commit, e_st, e_clr;
    int          e_ctag, e_stag;
    logic [31:0] e_cval, e_cpc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D; i++) begin
            m_ready[i] = 1'b0;
            m_val[i]   = '0;
        end
        m_tail   = 0;
        e_commit = 0; e_st = 0; e_clr = 0;
        e_ctag   = 0; e_stag = 0;
        e_cval   = '0; e_cpc = '0;
    endtask

    task automatic check_all();
        bit          r1, r2;
        logic [31:0] v1, v2;
        r1 = m_ready[query_tag_1] || (cdb_signal && (cdb_tag == query_tag_1));
        r2 = m_ready[query_tag_2] || (cdb_signal && (cdb_tag == query_tag_2));
        v1 = (cdb_signal && (cdb_tag == query_tag_1)) ? cdb_value : m_val[query_tag_1];
        v2 = (cdb_signal && (cdb_tag == query_tag_2)) ? cdb_value : m_val[query_tag_2];
        chk("issue_tag", 32'(issue_tag), 32'(m_tail));
        chk("rob_full", 32'(rob_full), 32'(q.size() == D));
        chk("query_ready_1", 32'(query_ready_1), 32'(r1));
        chk("query_ready_2", 32'(query_ready_2), 32'(r2));
        if (r1) chk("query_value_1", query_value_1, v1);
        if (r2) chk("query_value_2", query_value_2, v2);
        chk("rob_commit_signal", 32'(rob_commit_signal), 32'(e_commit));
        chk("commit_rd_tag", 32'(commit_rd_tag), 32'(e_ctag));
        chk("commit_rd_value", commit_rd_value, e_cval);
        chk("store_commit_signal", 32'(store_commit_signal), 32'(e_st));
        chk("store_commit_tag", 32'(store_commit_tag), 32'(e_stag));
        chk("clear_signal", 32'(clear_signal), 32'(e_clr));
        chk("clear_pc", clear_pc, e_cpc);
    endtask

    // Applies the retirement rules for one clock edge using the inputs
    // currently driven.
    task automatic model_edge();
        bit          do_commit, do_issue;
        int          h;
        logic [31:0] hv, hn, hp;
        logic [4:0]  hrd;
        bit          hbr, hst;
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            e_commit = 0;
            e_st     = 0;
            if (e_clr) begin
                e_clr = 0;
            end else begin
                do_commit = (q.size() > 0) && m_ready[q[0]];
                do_issue  = issue_signal && (q.size() < D);
                h   = do_commit ? q[0] : 0;
                hv  = m_val[h];  hn  = m_npc[h]; hp = m_pred[h];
                hrd = m_rd[h];   hbr = m_br[h];  hst = m_st[h];
                if (cdb_signal) begin
                    m_ready[cdb_tag] = 1'b1;
                    m_val[cdb_tag]   = cdb_value;
                    m_npc[cdb_tag]   = cdb_next_pc;
                end
                if (do_issue) begin
                    m_ready[m_tail] = 1'b0;
                    m_rd[m_tail]    = issue_rd_id;
                    m_br[m_tail]    = issue_is_branch;
                    m_st[m_tail]    = issue_is_store;
                    m_pred[m_tail]  = issue_pred_pc;
                    q.push_back(m_tail);
                    m_tail = (m_tail + 1) % D;
                end
                if (do_commit) begin
                    void'(q.pop_front());
                    if (hrd != 0) begin
                        e_commit = 1; e_ctag = h; e_cval = hv;
                    end
                    if (hst) begin
                        e_st = 1; e_stag = h;
                    end
                    if (hbr && (hn != hp)) begin
                        q.delete();
                        m_tail = 0;
                        for (int i = 0; i < D; i++) m_ready[i] = 1'b0;
                        e_clr = 1;
                        e_cpc = hn;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(bit en, logic [4:0] rd, bit br, bit st, logic [31:0] pred);
        issue_signal    = en;
        issue_rd_id     = rd;
        issue_is_branch = br;
        issue_is_store  = st;
        issue_pred_pc   = pred;
    endtask

    task automatic set_cdb(bit en, logic [W-1:0] tag, logic [31:0] val, logic [31:0] npc);
        cdb_signal  = en;
        cdb_tag     = tag;
        cdb_value   = val;
        cdb_next_pc = npc;
    endtask

    task automatic do_reset();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(0, 0, 0, 0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        int cands[$];
        int pick;
        @(posedge clk_in);
        #1;
        model_reset();
        do_reset();
        tick();

        // In-order retirement with out-of-order completion
        for (int i = 0; i < 3; i++) begin
            set_issue(1, 5'(5 + i), 0, 0, 0);
            tick();
        end
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 2, 30, 0); tick();
        set_cdb(1, 0, 10, 0); tick();
        set_cdb(1, 1, 20, 0); tick();
        set_cdb(0, 0, 0, 0);
        repeat (5) tick();

        // Fill to full, 17th ignored, commit with issue while full
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_issue(1, 5'(i + 1), 0, 0, 0);
            tick();
        end
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 0, 32'h100, 0); tick();
        set_cdb(0, 0, 0, 0);
        set_issue(1, 9, 0, 0, 0); tick();
        tick();
        set_issue(0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            set_cdb(1, W'(i % D), 32'(i * 3), 0);
            tick();
        end
        set_cdb(0, 0, 0, 0);
        repeat (18) tick();

        // Mispredicted JAL-style branch with younger entries, issue held high
        do_reset();
        set_issue(1, 1, 1, 0, 32'h104); tick();
        set_issue(1, 2, 0, 0, 0);       tick();
        set_issue(1, 3, 0, 0, 0);       tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 1, 32'h11, 0);       tick();
        set_cdb(1, 0, 32'h108, 32'h200);
        set_issue(1, 4, 0, 0, 0);       tick();
        set_cdb(0, 0, 0, 0);
        repeat (3) tick();
        set_issue(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Query bypass of same-cycle CDB
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 5'(10 + i), 0, 0, 0);
            tick();
        end
        set_issue(0, 0, 0, 0, 0);
        query_tag_1 = 3;
        query_tag_2 = 2;
        set_cdb(1, 3, 32'hABCD, 0); tick();
        set_cdb(0, 0, 0, 0);
        query_tag_2 = 3;
        tick();

        // Store, then rd=0 register op
        do_reset();
        set_issue(1, 0, 0, 1, 0); tick();
        set_issue(1, 0, 0, 0, 0); tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 0, 32'h77, 0); tick();
        set_cdb(1, 1, 32'h88, 0); tick();
        set_cdb(0, 0, 0, 0);
        repeat (4) tick();

        // Stall with rdy_in low while a commit is pending
        do_reset();
        set_issue(1, 9, 0, 0, 0); tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 0, 32'h55, 0); tick();
        set_cdb(0, 0, 0, 0);
        rdy_in = 1'b0;
        repeat (4) tick();
        rdy_in = 1'b1;
        repeat (4) tick();

        // Reset arriving during a flush cycle
        do_reset();
        set_issue(1, 0, 1, 0, 32'h10); tick();
        set_issue(0, 0, 0, 0, 0);
        set_cdb(1, 0, 0, 32'h20); tick();
        set_cdb(0, 0, 0, 0);
        tick();
        rst_in = 1'b1; tick();
        rst_in = 1'b0;
        repeat (2) tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst_in = ($urandom_range(0, 299) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            set_issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom);
            if (issue_is_branch) issue_is_store = 1'b0;
            cands.delete();
            foreach (q[k]) if (!m_ready[q[k]]) cands.push_back(q[k]);
            if ((cands.size() > 0) && ($urandom_range(0, 2) != 0)) begin
                pick = cands[$urandom_range(0, cands.size() - 1)];
                set_cdb(1, W'(pick), $urandom,
                        ($urandom_range(0, 3) == 0) ? $urandom : m_pred[pick]);
            end else begin
                set_cdb(0, W'($urandom_range(0, D - 1)), $urandom, $urandom);
            end
            query_tag_1 = W'($urandom_range(0, D - 1));
            query_tag_2 = W'($urandom_range(0, D - 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
